wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
Writeback stage plus architectural register file for the 5-stage RV32I core. It consumes the MEM→WB pipeline register outputs and selects the writeback value. It commits that value into a 32×32 register file and serves the two ID-stage read ports, with same-cycle write-to-read bypass. It also exposes the committed writeback to the forwarding unit and keeps a 64-bit retired-instruction counter.

Parameters:
- XLEN, 32, data width
- NREGS, 32, number of architectural registers (x0 hardwired to zero)
- CNT_W, 64, retired-instruction counter width

Ports:
- ACLK  in  1  system clock
- ARESET  in  1  synchronous, active-high reset
- stall_c_i  in  1  WB stall; while high, nothing commits and the counter holds
- valid_i  in  1  MEM→WB slot holds a real instruction (0 = bubble)
- rd_i  in  5  destination register
- alu_result_i  in  XLEN  ALU result
- pc_next_i  in  XLEN  PC+4 (JAL/JALR link value)
- mem_read_data_i  in  XLEN  load data, already extended by the MEM stage
- reg_write_c_i  in  1  register write enable
- wb_data_sel_c_i  in  2  writeback source select (wb_data_sel_t)
- rs1_i  in  5  ID read address 1
- rs2_i  in  5  ID read address 2
- rs1_data_o  out  XLEN  read data 1
- rs2_data_o  out  XLEN  read data 2
- wb_we_o  out  1  a commit happens this cycle (to the forwarding unit)
- wb_rd_o  out  5  commit destination
- wb_data_o  out  XLEN  selected writeback value
- instret_o  out  CNT_W  retired-instruction count
- sel_err_o  out  1  sticky flag: write requested with an illegal select

Behaviour:
- Clock and reset: single clock ACLK; reset ARESET is synchronous and active-high. All state is sampled on the ACLK rising edge.
- Reset (ARESET=1 at an edge):
  - x1..x31 ← 0
  - instret_o ← 0
  - sel_err_o ← 0
  - Reset mid-stream wins over any pending commit in the same cycle.
- Writeback select (combinational):
  - WB_SEL_ALU → alu_result_i
  - WB_SEL_MEM → mem_read_data_i
  - WB_SEL_PC → pc_next_i
  - WB_SEL_UNKNOWN → 0
  - wb_data_o always shows the selected value.
- Commit condition (combinational): commit = valid_i & reg_write_c_i & !stall_c_i & (rd_i≠0) & (sel≠WB_SEL_UNKNOWN).
  - wb_we_o = commit
  - wb_rd_o = rd_i
- Register write:
  - On an edge with commit=1 and ARESET=0, regs[rd_i] ← wb_data_o.
  - Writes to x0 are dropped; x0 always reads 0.
- Reads (combinational, zero latency):
  - Address 0 → 0.
  - Else if commit and rs==rd_i → wb_data_o (bypass, write-first).
  - Else → regs[rs].
  - Both ports may bypass simultaneously, including rs1_i==rs2_i.
- Retire counter:
  - Increments by 1 on an edge with valid_i & !stall_c_i & !ARESET, whether or not the instruction writes a register (stores and branches count).
  - Wraps modulo 2^CNT_W with no flag.
- sel_err_o:
  - Set on an edge where valid_i & reg_write_c_i & !stall_c_i & sel==WB_SEL_UNKNOWN.
  - Cleared only by reset.
  - The offending write is suppressed; the instruction still counts as retired.
- Stall: nothing commits, wb_we_o=0, and the counter holds. Reads stay live and return the stored values (no bypass).
- Latency: read after write is 0 cycles through the bypass. From the next edge onward the value comes from storage.

Decomposition:
- Shared package core_pkg holds:
  - types data_t, reg_addr_t, enable_t
  - wb_data_sel_t as a 2-bit enum: WB_SEL_ALU=0, WB_SEL_MEM=1, WB_SEL_PC=2, WB_SEL_UNKNOWN=3
  - constants REG_ZERO, DATA_ZERO, ENABLE, DISABLE
- One sub-module, regfile_2r1w: storage, x0 handling, write-first bypass, synchronous reset clear.
- wb_regfile keeps the select mux, commit logic, counter and error flag.

Test Plan:
- Reset then read: ARESET=1 for 2 cycles, then rs1_i=5, rs2_i=31 → both data outputs 0; instret_o=0; sel_err_o=0.
- Bypass and commit: valid=1, we=1, rd=3, sel=ALU, alu=0xDEADBEEF, rs1=rs2=3 → both reads 0xDEADBEEF in the same cycle and wb_we_o=1. Next cycle with valid=0 → reads still 0xDEADBEEF; instret_o=1.
- Source select: sel=MEM with mem data 0x12345678 → x4=0x12345678; sel=PC with pc_next 0x80 → x5=0x80.
- x0 protection: rd=0, we=1, alu=0xFFFFFFFF → wb_we_o=0; reading x0 gives 0; instret_o increments.
- Stall: x6=0x11, then stall=1 with rd=6, alu=0x22 → read of x6 gives 0x11, instret_o unchanged. Deassert stall → x6=0x22, counter +1.
- Illegal select and reset mid-op: sel=UNKNOWN, we=1, rd=7 → x7 unchanged and sel_err_o=1 next cycle. Then assert ARESET in the same cycle as a valid write to x8 → x8=0, instret_o=0, sel_err_o=0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the RV32I core pipeline.
// Holds the writeback select encoding used between decode and the WB stage.
package core_pkg;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int CNT_W  = 64;
    localparam int REG_AW = 5;

    typedef logic [XLEN-1:0]   data_t;
    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic              enable_t;

    typedef enum logic [1:0] {
        WB_SEL_ALU     = 2'd0,
        WB_SEL_MEM     = 2'd1,
        WB_SEL_PC      = 2'd2,
        WB_SEL_UNKNOWN = 2'd3
    } wb_data_sel_t;

    localparam reg_addr_t REG_ZERO  = '0;
    localparam data_t     DATA_ZERO = '0;
    localparam enable_t   ENABLE    = 1'b1;
    localparam enable_t   DISABLE   = 1'b0;

endpackage

// File: rtl/regfile_2r1w.sv
// Two-read / one-write architectural register file.
// x0 reads as zero; a same-cycle write is forwarded to matching read ports.
module regfile_2r1w
    import core_pkg::*;
#(
    parameter int XLEN  = core_pkg::XLEN,
    parameter int NREGS = core_pkg::NREGS,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            ACLK,
    input  logic            ARESET,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] regs_reg [NREGS];
    logic [AW-1:0]   raddr_arr [2];
    logic [XLEN-1:0] rdata_arr [2];

    // Entry 0 is cleared by reset and never written, so it stays zero.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs_reg[waddr] <= wdata;
        end
    end

    assign raddr_arr[0] = raddr1;
    assign raddr_arr[1] = raddr2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rport
            always_comb begin
                rdata_arr[gi] = regs_reg[raddr_arr[gi]];
                if (raddr_arr[gi] == '0) begin
                    rdata_arr[gi] = '0;
                end else if (we && (raddr_arr[gi] == waddr)) begin
                    rdata_arr[gi] = wdata;
                end
            end
        end
    endgenerate

    assign rdata1 = rdata_arr[0];
    assign rdata2 = rdata_arr[1];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects the result, commits it to the register file,
// exposes the commit to forwarding and counts retired instructions.
module wb_regfile
    import core_pkg::*;
#(
    parameter int XLEN  = core_pkg::XLEN,
    parameter int NREGS = core_pkg::NREGS,
    parameter int CNT_W = core_pkg::CNT_W
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             stall_c_i,
    input  logic             valid_i,
    input  logic [4:0]       rd_i,
    input  logic [XLEN-1:0]  alu_result_i,
    input  logic [XLEN-1:0]  pc_next_i,
    input  logic [XLEN-1:0]  mem_read_data_i,
    input  logic             reg_write_c_i,
    input  logic [1:0]       wb_data_sel_c_i,
    input  logic [4:0]       rs1_i,
    input  logic [4:0]       rs2_i,
    output logic [XLEN-1:0]  rs1_data_o,
    output logic [XLEN-1:0]  rs2_data_o,
    output logic             wb_we_o,
    output logic [4:0]       wb_rd_o,
    output logic [XLEN-1:0]  wb_data_o,
    output logic [CNT_W-1:0] instret_o,
    output logic             sel_err_o
);

    wb_data_sel_t     sel;
    logic [XLEN-1:0]  wb_data;
    logic             retire;
    logic             write_req;
    logic             commit;
    logic [CNT_W-1:0] instret_reg;
    logic [CNT_W-1:0] instret_next;
    logic             sel_err_reg;
    logic             sel_err_next;

    assign sel = wb_data_sel_t'(wb_data_sel_c_i);

    always_comb begin
        wb_data = '0;
        case (sel)
            WB_SEL_ALU: wb_data = alu_result_i;
            WB_SEL_MEM: wb_data = mem_read_data_i;
            WB_SEL_PC:  wb_data = pc_next_i;
            default:    wb_data = '0;
        endcase
    end

    assign retire    = valid_i & ~stall_c_i;
    assign write_req = retire & reg_write_c_i;
    assign commit    = write_req & (rd_i != REG_ZERO) & (sel != WB_SEL_UNKNOWN);

    regfile_2r1w #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .AW    (5)
    ) u_regfile (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .we     (commit),
        .waddr  (rd_i),
        .wdata  (wb_data),
        .raddr1 (rs1_i),
        .raddr2 (rs2_i),
        .rdata1 (rs1_data_o),
        .rdata2 (rs2_data_o)
    );

    // Stores and branches retire too, so the counter ignores reg_write.
    always_comb begin
        instret_next = instret_reg;
        sel_err_next = sel_err_reg;
        if (retire) begin
            instret_next = instret_reg + CNT_W'(1);
        end
        if (write_req && (sel == WB_SEL_UNKNOWN)) begin
            sel_err_next = ENABLE;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            instret_reg <= '0;
            sel_err_reg <= DISABLE;
        end else begin
            instret_reg <= instret_next;
            sel_err_reg <= sel_err_next;
        end
    end

    assign wb_we_o   = commit;
    assign wb_rd_o   = rd_i;
    assign wb_data_o = wb_data;
    assign instret_o = instret_reg;
    assign sel_err_o = sel_err_reg;

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized scoreboard bench for wb_regfile against a behavioural model
// of the architectural register file, retire counter and error flag.
module tb_wb_regfile;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        stall_c_i;
    logic        valid_i;
    logic [4:0]  rd_i;
    logic [31:0] alu_result_i;
    logic [31:0] pc_next_i;
    logic [31:0] mem_read_data_i;
    logic        reg_write_c_i;
    logic [1:0]  wb_data_sel_c_i;
    logic [4:0]  rs1_i;
    logic [4:0]  rs2_i;
    logic [31:0] rs1_data_o;
    logic [31:0] rs2_data_o;
    logic        wb_we_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic [63:0] instret_o;
    logic        sel_err_o;

    wb_regfile dut (
        .ACLK            (ACLK),
        .ARESET          (ARESET),
        .stall_c_i       (stall_c_i),
        .valid_i         (valid_i),
        .rd_i            (rd_i),
        .alu_result_i    (alu_result_i),
        .pc_next_i       (pc_next_i),
        .mem_read_data_i (mem_read_data_i),
        .reg_write_c_i   (reg_write_c_i),
        .wb_data_sel_c_i (wb_data_sel_c_i),
        .rs1_i           (rs1_i),
        .rs2_i           (rs2_i),
        .rs1_data_o      (rs1_data_o),
        .rs2_data_o      (rs2_data_o),
        .wb_we_o         (wb_we_o),
        .wb_rd_o         (wb_rd_o),
        .wb_data_o       (wb_data_o),
        .instret_o       (instret_o),
        .sel_err_o       (sel_err_o)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wbd;
        logic [63:0] cnt;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_txn    = 0;
    logic [31:0] mregs [32];
    logic [63:0] mcnt;
    logic        merr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s txn %0d: got %h expected %h", name, n_txn, act, req);
        end
    endtask

    // Monitor: outputs are combinational, so each issued transaction is
    // observed on the falling edge that follows its stimulus.
    always @(negedge ACLK) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("rs1_data", 64'(rs1_data_o), 64'(e.rs1));
            check("rs2_data", 64'(rs2_data_o), 64'(e.rs2));
            check("wb_we",    64'(wb_we_o),    64'(e.we));
            check("wb_rd",    64'(wb_rd_o),    64'(e.rd));
            check("wb_data",  64'(wb_data_o),  64'(e.wbd));
            check("instret",  instret_o,       e.cnt);
            check("sel_err",  64'(sel_err_o),  64'(e.err));
            $display("txn %0d rst=%b stall=%b valid=%b we=%b rd=%0d sel=%0d rs1=%0d:%h rs2=%0d:%h instret=%0d err=%b",
                     n_txn, ARESET, stall_c_i, valid_i, reg_write_c_i, rd_i, wb_data_sel_c_i,
                     rs1_i, rs1_data_o, rs2_i, rs2_data_o, instret_o, sel_err_o);
            n_txn++;
        end
    end

    // One clock of stimulus: predict outputs from the model, queue them,
    // then advance the model across the edge.
    task automatic step(input bit rst, input bit stall, input bit valid, input bit we,
                        input logic [4:0] rd, input logic [1:0] sel,
                        input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc,
                        input logic [4:0] rs1, input logic [4:0] rs2);
        exp_t        e;
        logic [31:0] value;
        bit          commit;
        ARESET          = rst;
        stall_c_i       = stall;
        valid_i         = valid;
        reg_write_c_i   = we;
        rd_i            = rd;
        wb_data_sel_c_i = sel;
        alu_result_i    = alu;
        mem_read_data_i = mem;
        pc_next_i       = pc;
        rs1_i           = rs1;
        rs2_i           = rs2;
        case (sel)
            2'd0:    value = alu;
            2'd1:    value = mem;
            2'd2:    value = pc;
            default: value = 32'h0;
        endcase
        commit = valid && we && !stall && (rd != 0) && (sel != 2'd3);
        e.wbd = value;
        e.we  = commit;
        e.rd  = rd;
        e.cnt = mcnt;
        e.err = merr;
        e.rs1 = (rs1 == 0) ? 32'h0 : (commit && rs1 == rd) ? value : mregs[rs1];
        e.rs2 = (rs2 == 0) ? 32'h0 : (commit && rs2 == rd) ? value : mregs[rs2];
        exp_q.push_back(e);
        @(posedge ACLK);
        if (rst) begin
            for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
            mcnt = 64'h0;
            merr = 1'b0;
        end else begin
            if (valid && !stall) mcnt = mcnt + 64'h1;
            if (commit) mregs[rd] = value;
            if (valid && we && !stall && sel == 2'd3) merr = 1'b1;
        end
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESET = 1'b1; stall_c_i = 1'b0; valid_i = 1'b0; reg_write_c_i = 1'b0;
        rd_i = '0; wb_data_sel_c_i = '0; alu_result_i = '0; pc_next_i = '0;
        mem_read_data_i = '0; rs1_i = '0; rs2_i = '0;
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        mcnt = 64'h0;
        merr = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;

        // Reset state, then bypass and commit
        step(0, 0, 0, 0, 5'd0, 2'd0, 32'h0,        32'h0,        32'h0,  5'd5, 5'd31);
        step(0, 0, 1, 1, 5'd3, 2'd0, 32'hDEADBEEF, 32'h0,        32'h0,  5'd3, 5'd3);
        step(0, 0, 0, 0, 5'd0, 2'd0, 32'h0,        32'h0,        32'h0,  5'd3, 5'd3);
        // Source select
        step(0, 0, 1, 1, 5'd4, 2'd1, 32'h1,        32'h12345678, 32'h2,  5'd4, 5'd3);
        step(0, 0, 1, 1, 5'd5, 2'd2, 32'h3,        32'h4,        32'h80, 5'd4, 5'd5);
        step(0, 0, 0, 0, 5'd0, 2'd0, 32'h0,        32'h0,        32'h0,  5'd4, 5'd5);
        // x0 protection
        step(0, 0, 1, 1, 5'd0, 2'd0, 32'hFFFFFFFF, 32'h0,        32'h0,  5'd0, 5'd0);
        // Stall holds everything, release commits
        step(0, 0, 1, 1, 5'd6, 2'd0, 32'h11,       32'h0,        32'h0,  5'd6, 5'd0);
        step(0, 1, 1, 1, 5'd6, 2'd0, 32'h22,       32'h0,        32'h0,  5'd6, 5'd6);
        step(0, 0, 1, 1, 5'd6, 2'd0, 32'h22,       32'h0,        32'h0,  5'd6, 5'd6);
        step(0, 0, 0, 0, 5'd0, 2'd0, 32'h0,        32'h0,        32'h0,  5'd6, 5'd0);
        // Illegal select, then reset racing a write to x8
        step(0, 0, 1, 1, 5'd7, 2'd3, 32'h77,       32'h77,       32'h77, 5'd7, 5'd7);
        step(0, 0, 1, 1, 5'd8, 2'd0, 32'h88,       32'h0,        32'h0,  5'd7, 5'd8);
        step(0, 0, 0, 0, 5'd0, 2'd0, 32'h0,        32'h0,        32'h0,  5'd8, 5'd7);
        step(1, 0, 1, 1, 5'd8, 2'd0, 32'h99,       32'h0,        32'h0,  5'd8, 5'd3);
        step(0, 0, 0, 0, 5'd0, 2'd0, 32'h0,        32'h0,        32'h0,  5'd8, 5'd3);

        // Randomized traffic, concentrated on few registers to exercise bypass
        for (int n = 0; n < 400; n++) begin
            bit          r_rst, r_stall, r_valid, r_we;
            logic [4:0]  r_rd, r_rs1, r_rs2;
            logic [1:0]  r_sel;
            r_rst   = ($urandom_range(0, 59) == 0);
            r_stall = ($urandom_range(0, 4) == 0);
            r_valid = ($urandom_range(0, 3) != 0);
            r_we    = ($urandom_range(0, 3) != 0);
            r_rd    = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            r_sel   = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            r_rs1   = ($urandom_range(0, 2) == 0) ? r_rd : 5'($urandom_range(0, 7));
            r_rs2   = ($urandom_range(0, 2) == 0) ? r_rd : 5'($urandom_range(0, 31));
            step(r_rst, r_stall, r_valid, r_we, r_rd, r_sel,
                 $urandom, $urandom, $urandom, r_rs1, r_rs2);
        end

        @(negedge ACLK);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
